// File: rtl/flit_drain_pkg.sv
// Shared NoC definitions: flit type encodings, type-field position and drain/skid constants.
package flit_drain_pkg;

  // The flit type occupies the FLIT_TYPE_W most significant bits of every flit.
  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } drain_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_OCC_W = 2;

endpackage

// File: rtl/flit_skid.sv
// Two-entry output FIFO; the head entry drives the output directly from registers.
module flit_skid
  import flit_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic [DATA_WIDTH-1:0] in_dat_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  output logic [SKID_OCC_W-1:0] occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [SKID_OCC_W-1:0] occ_q;
  logic [SKID_OCC_W-1:0] occ_d;
  logic                  push;
  logic                  pop;

  assign out_vld_o = (occ_q != '0);
  // A full skid can still take a flit in the same cycle its head leaves.
  assign in_rdy_o  = (occ_q != SKID_OCC_W'(SKID_DEPTH)) | out_rdy_i;
  assign push      = in_vld_i & in_rdy_o;
  assign pop       = out_vld_o & out_rdy_i;
  assign out_dat_o = mem_q[rd_ptr_q];
  assign occ_o     = occ_q;
  assign occ_d     = occ_q + SKID_OCC_W'(push) - SKID_OCC_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/flit_drain.sv
// Drains flits from an upstream buffer through a 2-entry skid and checks packet framing.
// Reads are throttled so the one-cycle-late buffer data always has a free skid slot.
module flit_drain
  import flit_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  buf_not_empty,
  output logic                  buf_rd_en,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  in_pkt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  err_proto,
  input  logic                  clr_err
);

  logic                  rd_arm_q;
  logic                  inflight_q;
  logic                  skid_in_rdy;
  logic [SKID_OCC_W-1:0] skid_occ;
  logic                  pop;
  logic [2:0]            budget;
  flit_type_e            ftype;
  drain_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  cnt_inc;
  logic                  err_set;

  assign pop    = flit_valid & flit_ready;
  // Slots committed after this edge: what the skid keeps plus the flit still returning.
  assign budget = {1'b0, skid_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign buf_rd_en = rd_arm_q & buf_not_empty & skid_in_rdy & (budget < 3'd2);

  // rd_arm_q holds reads off for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_arm_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      rd_arm_q   <= 1'b1;
      inflight_q <= buf_rd_en;
    end
  end

  flit_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (inflight_q),
    .in_rdy_o  (skid_in_rdy),
    .in_dat_i  (buf_data),
    .out_vld_o (flit_valid),
    .out_rdy_i (flit_ready),
    .out_dat_o (flit_out),
    .occ_o     (skid_occ)
  );

  assign ftype = flit_type_e'(flit_out[DATA_WIDTH-1 -: FLIT_TYPE_W]);

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    if (pop) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (ftype)
            FT_HEAD:   state_d = ST_PKT;
            FT_SINGLE: cnt_inc = 1'b1;
            default:   err_set = 1'b1;
          endcase
        end
        ST_PKT: begin
          unique case (ftype)
            FT_BODY: state_d = ST_PKT;
            FT_TAIL: begin
              state_d = ST_IDLE;
              cnt_inc = 1'b1;
            end
            FT_HEAD: err_set = 1'b1;
            FT_SINGLE: begin
              state_d = ST_IDLE;
              err_set = 1'b1;
              cnt_inc = 1'b1;
            end
          endcase
        end
      endcase
    end
    cnt_d = cnt_q + CNT_WIDTH'(cnt_inc);
    // A new error outranks a simultaneous clear.
    err_d = err_set | (err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_pkt    = (state_q == ST_PKT);
  assign pkt_cnt   = cnt_q;
  assign err_proto = err_q;

endmodule

// File: tb/tb_flit_drain.sv
// Bench for flit_drain: upstream buffer model, output scoreboard, framing vector table.
module tb_flit_drain;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buf_not_empty = 1'b0;
  logic          buf_rd_en;
  logic [DW-1:0] buf_data = '0;
  logic [DW-1:0] flit_out;
  logic          flit_valid;
  logic          flit_ready = 1'b0;
  logic          in_pkt;
  logic [CW-1:0] pkt_cnt;
  logic          err_proto;
  logic          clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] exp_q[$];
  int            xfer_cyc[$];

  logic [DW-1:0] nxt_dat;
  logic          have_nxt = 1'b0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_dat = '0;
  int            rd_tot = 0;
  int            xf_tot = 0;

  typedef struct {
    logic [DW-1:0] flit;
    logic          clr;
    logic          exp_in_pkt;
    logic          exp_err;
    logic [CW-1:0] exp_cnt;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  flit_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buf_not_empty (buf_not_empty),
    .buf_rd_en     (buf_rd_en),
    .buf_data      (buf_data),
    .flit_out      (flit_out),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .in_pkt        (in_pkt),
    .pkt_cnt       (pkt_cnt),
    .err_proto     (err_proto),
    .clr_err       (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Buffer model and output scoreboard: decisions at negedge, read data returned after posedge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        have_nxt = 1'b0;
        stall_q  = 1'b0;
        rd_tot   = 0;
        xf_tot   = 0;
      end else begin
        if (stall_q) begin
          check("stall_valid", 32'(flit_valid), 32'd1);
          check("stall_stable", flit_out, stall_dat);
        end
        check("outstanding_le2", 32'(rd_tot - xf_tot <= 2), 32'd1);
        if (flit_valid && flit_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit: got 0x%0h, required none", flit_out);
          end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (flit_out !== e) begin
              errors++;
              $display("FAIL flit_order: got 0x%0h, required 0x%0h", flit_out, e);
            end
          end
          xf_tot++;
          xfer_cyc.push_back(cyc);
        end
        stall_q   = flit_valid & ~flit_ready;
        stall_dat = flit_out;
        if (buf_rd_en) begin
          if (buf_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_when_empty: got buf_rd_en=1, required 0");
          end else begin
            nxt_dat  = buf_q.pop_front();
            have_nxt = 1'b1;
          end
          rd_tot++;
        end
      end
      @(posedge clk);
      #1;
      if (have_nxt) begin
        buf_data = nxt_dat;
        have_nxt = 1'b0;
      end
      buf_not_empty = (buf_q.size() != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] f);
    buf_q.push_back(f);
    exp_q.push_back(f);
    buf_not_empty = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d flits left after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic reset_seq(input logic with_flit, input logic [DW-1:0] f);
    rst_n   = 1'b0;
    clr_err = 1'b0;
    buf_q.delete();
    exp_q.delete();
    buf_not_empty = 1'b0;
    @(negedge clk);
    check("rst_buf_rd_en", 32'(buf_rd_en), 32'd0);
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_in_pkt", 32'(in_pkt), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err_proto", 32'(err_proto), 32'd0);
    step();
    if (with_flit) push(f);
    rst_n = 1'b1;
    @(negedge clk);
    if (with_flit) check("no_rd_first_cycle", 32'(buf_rd_en), 32'd0);
    step();
  endtask

  initial begin
    int n;
    int base;
    int push_cyc;
    logic [CW-1:0] cnt_exp;

    // flit, clr, in_pkt, err, cnt -- expectations after the flit transfers (or clr pulse)
    tbl[0]  = '{32'h0000_00AA, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[1]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{32'h4000_0001, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{32'h0000_0002, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[4]  = '{32'h4000_0003, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[5]  = '{32'h8000_0004, 1'b0, 1'b0, 1'b1, 4'd1};
    tbl[6]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[7]  = '{32'h8000_0005, 1'b0, 1'b0, 1'b1, 4'd1};
    tbl[8]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[9]  = '{32'hC000_0006, 1'b0, 1'b0, 1'b0, 4'd2};
    tbl[10] = '{32'h4000_0007, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[11] = '{32'hC000_0008, 1'b0, 1'b0, 1'b1, 4'd3};
    tbl[12] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'd3};
    tbl[13] = '{32'h4000_0009, 1'b0, 1'b1, 1'b0, 4'd3};
    tbl[14] = '{32'h0000_000A, 1'b0, 1'b1, 1'b0, 4'd3};
    tbl[15] = '{32'h8000_000B, 1'b0, 1'b0, 1'b0, 4'd4};

    // Counter wrap: 17 singles on a 4-bit counter land on 1.
    reset_seq(1'b0, '0);
    flit_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(32'hC000_0000);
    wait_drain("wrap_drain", 200);
    check("wrap_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("wrap_err", 32'(err_proto), 32'd0);

    // Framing table; the gap before the last tail leaves the buffer empty mid-packet.
    reset_seq(1'b0, '0);
    flit_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].clr) begin
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
      end else begin
        push(tbl[i].flit);
        wait_drain($sformatf("vec%0d_drain", i), 20);
      end
      check($sformatf("vec%0d_in_pkt", i), 32'(in_pkt), 32'(tbl[i].exp_in_pkt));
      check($sformatf("vec%0d_err", i), 32'(err_proto), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_cnt", i), 32'(pkt_cnt), 32'(tbl[i].exp_cnt));
    end
    cnt_exp = 4'd4;

    // Error and clear in the same cycle: the error wins, a later clear then takes effect.
    flit_ready = 1'b0;
    push(32'h0000_00BB);
    n = 0;
    while (!flit_valid && n < 20) begin
      step();
      n++;
    end
    check("clrwin_valid", 32'(flit_valid), 32'd1);
    clr_err    = 1'b1;
    flit_ready = 1'b1;
    step();
    clr_err = 1'b0;
    check("clrwin_err", 32'(err_proto), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_after_err", 32'(err_proto), 32'd0);

    // Stream: first flit shows three negedges after the push, rest back-to-back.
    base     = xfer_cyc.size();
    push_cyc = cyc;
    push(32'h4000_0001);
    push(32'h0000_0002);
    push(32'h8000_0003);
    wait_drain("stream_drain", 30);
    cnt_exp = cnt_exp + 4'd1;
    check("stream_latency", 32'(xfer_cyc[base]), 32'(push_cyc + 3));
    check("stream_b2b_1", 32'(xfer_cyc[base+1] - xfer_cyc[base]), 32'd1);
    check("stream_b2b_2", 32'(xfer_cyc[base+2] - xfer_cyc[base+1]), 32'd1);
    check("stream_cnt", 32'(pkt_cnt), 32'(cnt_exp));
    check("stream_err", 32'(err_proto), 32'd0);

    // Backpressure: ready pattern 1,0,0 repeating over an 8-flit packet.
    push(32'h4000_0100);
    for (int i = 1; i < 7; i++) push(32'h0000_0100 + 32'(i));
    push(32'h8000_0107);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      flit_ready = (n % 3 == 0);
      step();
      n++;
    end
    flit_ready = 1'b1;
    wait_drain("bp_drain", 10);
    cnt_exp = cnt_exp + 4'd1;
    check("bp_cnt", 32'(pkt_cnt), 32'(cnt_exp));
    check("bp_err", 32'(err_proto), 32'd0);

    // Reset after the head has gone out, with the following body still returning.
    push(32'h4000_0010);
    push(32'h0000_0011);
    push(32'h0000_0012);
    n = 0;
    while (!in_pkt && n < 20) begin
      step();
      n++;
    end
    check("mid_in_pkt", 32'(in_pkt), 32'd1);
    reset_seq(1'b1, 32'h4000_0020);
    push(32'h8000_0021);
    wait_drain("mid_after_drain", 30);
    check("mid_after_in_pkt", 32'(in_pkt), 32'd0);
    check("mid_after_cnt", 32'(pkt_cnt), 32'd1);
    check("mid_after_err", 32'(err_proto), 32'd0);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
